// File: rtl/sound_mixer_seq_if.sv
// sound_mixer_seq_if: control, channel-level and stereo sample stream bundle between the
// channel generators, the sequential mixer and the audio output path.
interface sound_mixer_seq_if #(
    parameter int NCH = 4,
    parameter int LW  = 4,
    parameter int VW  = 3,
    parameter int OW  = 16
);
    logic              enable;
    logic              sample_tick;
    logic              clr_overrun;
    logic              out_ready;
    logic              out_valid;
    logic              busy;
    logic              overrun;
    logic [NCH*LW-1:0] levels;
    logic [NCH-1:0]    pan_l;
    logic [NCH-1:0]    pan_r;
    logic [VW-1:0]     vol_l;
    logic [VW-1:0]     vol_r;
    logic [OW-1:0]     out_l;
    logic [OW-1:0]     out_r;

    modport master (
        output enable, sample_tick, clr_overrun, out_ready, levels, pan_l, pan_r, vol_l, vol_r,
        input  out_valid, busy, overrun, out_l, out_r
    );

    modport slave (
        input  enable, sample_tick, clr_overrun, out_ready, levels, pan_l, pan_r, vol_l, vol_r,
        output out_valid, busy, overrun, out_l, out_r
    );
endinterface

// File: rtl/sound_mixer_seq.sv
// sound_mixer_seq: time-multiplexed NCH-channel stereo mixer with panning and master volume,
// emitting PCM sample pairs on a valid/ready stream.
module sound_mixer_seq #(
    parameter int NCH         = 4,
    parameter int LW          = 4,
    parameter int VW          = 3,
    parameter int OW          = 16,
    parameter int SIGNED_MODE = 0
) (
    input logic              clk,
    input logic              rst,
    sound_mixer_seq_if.slave bus
);
    localparam int AW = LW + $clog2(NCH);
    localparam int PW = AW + VW;
    localparam int IW = NCH > 1 ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, SCALE, EMIT} state_t;

    state_t            state_q;
    logic [NCH*LW-1:0] lev_q;
    logic [NCH-1:0]    pl_q, pr_q;
    logic [VW-1:0]     vl_q, vr_q;
    logic [IW-1:0]     idx_q;
    logic [AW-1:0]     acc_l_q, acc_r_q, term;
    logic [PW-1:0]     prod_l_q, prod_r_q;
    logic [OW-1:0]     out_l_q, out_r_q;
    logic              out_valid_q, overrun_q;
    logic [LW-1:0]     lvl;
    logic              start, load, set_ovr, last;

    // Sign-extends the accumulator in centred mode so the low PW bits of the product are exact.
    function automatic logic [PW-1:0] scale(input logic [AW-1:0] acc, input logic [VW-1:0] vol);
        logic [PW-1:0] ext;
        ext = {{VW{SIGNED_MODE != 0 && acc[AW-1]}}, acc};
        return ext * PW'({1'b0, vol} + 1'b1);
    endfunction

    assign lvl     = lev_q[idx_q*LW +: LW];
    assign term    = SIGNED_MODE != 0 ? AW'(lvl) - AW'(2**(LW-1)) : AW'(lvl);
    assign last    = idx_q == IW'(NCH-1);
    assign start   = state_q == IDLE && bus.sample_tick;
    assign load    = state_q == EMIT && (!out_valid_q || bus.out_ready);
    assign set_ovr = (state_q != IDLE && bus.sample_tick) || (state_q == EMIT && !load);

    assign bus.out_l     = out_l_q;
    assign bus.out_r     = out_r_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = state_q != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lev_q       <= '0;
            pl_q        <= '0;
            pr_q        <= '0;
            vl_q        <= '0;
            vr_q        <= '0;
            idx_q       <= '0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            prod_l_q    <= '0;
            prod_r_q    <= '0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (!bus.enable) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= overrun_q && !bus.clr_overrun;
        end else begin
            overrun_q <= set_ovr || (overrun_q && !bus.clr_overrun);
            case (state_q)
                IDLE: if (start) begin
                    lev_q   <= bus.levels;
                    pl_q    <= bus.pan_l;
                    pr_q    <= bus.pan_r;
                    vl_q    <= bus.vol_l;
                    vr_q    <= bus.vol_r;
                    acc_l_q <= '0;
                    acc_r_q <= '0;
                    idx_q   <= '0;
                    state_q <= ACCUM;
                end
                ACCUM: begin
                    acc_l_q <= acc_l_q + (pl_q[idx_q] ? term : '0);
                    acc_r_q <= acc_r_q + (pr_q[idx_q] ? term : '0);
                    idx_q   <= idx_q + 1'b1;
                    state_q <= last ? SCALE : ACCUM;
                end
                SCALE: begin
                    prod_l_q <= scale(acc_l_q, vl_q);
                    prod_r_q <= scale(acc_r_q, vr_q);
                    state_q  <= EMIT;
                end
                default: state_q <= IDLE;
            endcase
            if (load) begin
                out_l_q     <= OW'(prod_l_q) << (OW - PW);
                out_r_q     <= OW'(prod_r_q) << (OW - PW);
                out_valid_q <= 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sound_mixer_seq.sv
// tb_sound_mixer_seq: directed vectors for unsigned and centred mixer instances; expected
// sample pairs are queued at stimulus time and popped by per-instance output monitors.
module tb_sound_mixer_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sound_mixer_seq_if #(.NCH(4), .LW(4), .VW(3), .OW(16)) u_if ();
    sound_mixer_seq_if #(.NCH(4), .LW(4), .VW(3), .OW(16)) s_if ();

    sound_mixer_seq #(.NCH(4), .LW(4), .VW(3), .OW(16), .SIGNED_MODE(0)) dut_u (
        .clk(clk), .rst(rst), .bus(u_if.slave));
    sound_mixer_seq #(.NCH(4), .LW(4), .VW(3), .OW(16), .SIGNED_MODE(1)) dut_s (
        .clk(clk), .rst(rst), .bus(s_if.slave));

    int total = 0;
    int bad = 0;
    logic [31:0] qu[$];
    logic [31:0] qs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_u();
        u_if.sample_tick = 1'b1;
        step(1);
        u_if.sample_tick = 1'b0;
    endtask

    task automatic tick_s();
        s_if.sample_tick = 1'b1;
        step(1);
        s_if.sample_tick = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && u_if.out_valid && u_if.out_ready) begin
            if (qu.size() == 0) begin
                total++;
                bad++;
                $display("FAIL u_out unexpected act=%h", {u_if.out_l, u_if.out_r});
            end else begin
                chk("u_out", {u_if.out_l, u_if.out_r}, qu.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && s_if.out_valid && s_if.out_ready) begin
            if (qs.size() == 0) begin
                total++;
                bad++;
                $display("FAIL s_out unexpected act=%h", {s_if.out_l, s_if.out_r});
            end else begin
                chk("s_out", {s_if.out_l, s_if.out_r}, qs.pop_front());
            end
        end
    end

    initial begin
        u_if.enable = 1'b1; u_if.sample_tick = 1'b0; u_if.clr_overrun = 1'b0; u_if.out_ready = 1'b1;
        u_if.levels = 16'hFFFF; u_if.pan_l = 4'hF; u_if.pan_r = 4'hF; u_if.vol_l = 3'd7; u_if.vol_r = 3'd7;
        s_if.enable = 1'b1; s_if.sample_tick = 1'b0; s_if.clr_overrun = 1'b0; s_if.out_ready = 1'b1;
        s_if.levels = 16'hFFFF; s_if.pan_l = 4'hF; s_if.pan_r = 4'hF; s_if.vol_l = 3'd7; s_if.vol_r = 3'd7;
        step(2);
        rst = 1'b0;
        chk("rst_u_out", {u_if.out_l, u_if.out_r}, 32'h0);
        chk("rst_u_flags", {29'd0, u_if.out_valid, u_if.busy, u_if.overrun}, 32'h0);
        chk("rst_s_out", {s_if.out_l, s_if.out_r}, 32'h0);
        chk("rst_s_flags", {29'd0, s_if.out_valid, s_if.busy, s_if.overrun}, 32'h0);

        // full-scale unsigned, exact latency and single-cycle valid
        qu.push_back(32'hF000_F000);
        tick_u();
        chk("t1_busy", u_if.busy, 1);
        for (int i = 1; i < 6; i++) begin
            step(1);
            chk("t1_lat_lo", u_if.out_valid, 0);
        end
        step(1);
        chk("t1_lat_hi", u_if.out_valid, 1);
        step(1);
        chk("t1_one_cycle", u_if.out_valid, 0);
        chk("t1_ovr", u_if.overrun, 0);

        // centred mode: max, min, midpoint
        qs.push_back(32'h7000_7000);
        tick_s();
        step(8);
        s_if.levels = 16'h0000;
        qs.push_back(32'h8000_8000);
        tick_s();
        step(8);
        s_if.levels = 16'h8888;
        qs.push_back(32'h0000_0000);
        tick_s();
        step(8);

        // single channel, left only, vol 3
        u_if.levels = 16'h000F; u_if.pan_l = 4'b0001; u_if.pan_r = 4'b0000; u_if.vol_l = 3'd3; u_if.vol_r = 3'd7;
        qu.push_back(32'h1E00_0000);
        tick_u();
        step(8);

        // backpressure: hold first, drop second, sticky overrun
        u_if.out_ready = 1'b0;
        u_if.levels = 16'h1234; u_if.pan_l = 4'hF; u_if.pan_r = 4'h5; u_if.vol_l = 3'd7; u_if.vol_r = 3'd1;
        qu.push_back(32'h2800_0600);
        tick_u();
        step(9);
        chk("t4_held_valid", u_if.out_valid, 1);
        chk("t4_held_val", {u_if.out_l, u_if.out_r}, 32'h2800_0600);
        chk("t4_no_ovr", u_if.overrun, 0);
        u_if.levels = 16'hFFFF; u_if.pan_r = 4'hF; u_if.vol_r = 3'd7;
        tick_u();
        step(8);
        chk("t4_drop_ovr", u_if.overrun, 1);
        chk("t4_stable", {u_if.out_l, u_if.out_r}, 32'h2800_0600);
        chk("t4_still_valid", u_if.out_valid, 1);
        u_if.clr_overrun = 1'b1;
        step(1);
        u_if.clr_overrun = 1'b0;
        chk("t4_clr", u_if.overrun, 0);
        u_if.out_ready = 1'b1;
        step(1);
        chk("t4_drained", u_if.out_valid, 0);
        step(2);
        chk("t4_one_xfer", u_if.out_valid, 0);

        // tick during ACCUM ignored; mid-ACCUM input changes have no effect
        u_if.levels = 16'h8421; u_if.pan_l = 4'hA; u_if.pan_r = 4'h5; u_if.vol_l = 3'd0; u_if.vol_r = 3'd7;
        qu.push_back(32'h0500_1400);
        tick_u();
        step(1);
        u_if.levels = 16'hFFFF; u_if.pan_l = 4'hF; u_if.pan_r = 4'hF; u_if.vol_l = 3'd7;
        tick_u();
        step(8);
        chk("t5_ovr", u_if.overrun, 1);
        u_if.clr_overrun = 1'b1;
        step(1);
        u_if.clr_overrun = 1'b0;
        chk("t5_clr", u_if.overrun, 0);

        // enable dropped during SCALE
        tick_u();
        step(4);
        u_if.enable = 1'b0;
        step(1);
        chk("t6_busy", u_if.busy, 0);
        chk("t6_valid", u_if.out_valid, 0);
        chk("t6_out", {u_if.out_l, u_if.out_r}, 32'h0);
        u_if.enable = 1'b1;
        step(2);

        // async reset mid-ACCUM while a sample is held
        u_if.out_ready = 1'b0;
        tick_u();
        step(8);
        chk("t6_hold", {u_if.out_l, u_if.out_r}, 32'hF000_F000);
        tick_u();
        step(1);
        #2 rst = 1'b1;
        #1;
        chk("t6_arst_out", {u_if.out_l, u_if.out_r}, 32'h0);
        chk("t6_arst_flags", {29'd0, u_if.out_valid, u_if.busy, u_if.overrun}, 32'h0);
        step(1);
        rst = 1'b0;
        u_if.out_ready = 1'b1;
        step(3);
        chk("q_u_empty", qu.size(), 0);
        chk("q_s_empty", qs.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sound_mixer_seq.md
Name: sound_mixer_seq

Overview:
Parametrised successor to the sound unit's combinational four-channel mixer. It time-multiplexes a single accumulator over NCH channel levels, applies per-side panning and master volume, and emits stereo PCM samples on a valid/ready stream. It sits between the channel generators and the audio output path (I2S/PWM serializer). Offset-binary (unsigned) and centred two's-complement mixing are selected at elaboration.

Parameters:
NCH, 4, number of input channels (>=1)
LW, 4, per-channel level width (unsigned level, 0..2^LW-1)
VW, 3, master volume width; gain = (vol+1)/2^VW
OW, 16, output sample width; must be >= PW (below)
SIGNED_MODE, 0, 0 = unsigned sum; 1 = each level re-centred to (level - 2^(LW-1)), two's-complement output

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
enable  in  1  master sound enable; low aborts and clears
sample_tick  in  1  one-cycle strobe requesting a new output sample
levels  in  NCH*LW  channel levels, ch k at [k*LW +: LW]
pan_l  in  NCH  bit k routes ch k to left
pan_r  in  NCH  bit k routes ch k to right
vol_l  in  VW  left master volume
vol_r  in  VW  right master volume
out_l  out  OW  left sample
out_r  out  OW  right sample
out_valid  out  1  sample pair valid
out_ready  in  1  downstream accepts when out_valid & out_ready
busy  out  1  high in any state other than IDLE
overrun  out  1  sticky: tick missed or sample dropped
clr_overrun  in  1  clears overrun

Behaviour:
- Widths: AW = LW + clog2(NCH) (+1 sign bit handled inside AW when SIGNED_MODE=1, i.e. AW = LW + clog2(NCH)); PW = AW + VW. Output = product << (OW - PW); unsigned zero-filled, signed keeps its sign. No saturation is needed; the ranges fit by construction.
- Reset: out_l = 0, out_r = 0, out_valid = 0, overrun = 0, busy = 0, state IDLE, accumulators 0.
- FSM states: IDLE, ACCUM, SCALE, EMIT.
- IDLE: on sample_tick & enable, snapshot levels, pan_l/r and vol_l/r into capture registers; clear acc_l/acc_r; idx = 0; go to ACCUM.
- ACCUM: one channel per cycle. acc_l += term if pan_l[idx]; acc_r += term if pan_r[idx]. term = level (unsigned) or level - 2^(LW-1) (signed). Go to SCALE after idx = NCH-1.
- SCALE: prod_l = acc_l * (vol_l+1), prod_r = acc_r * (vol_r+1), registered. Go to EMIT.
- EMIT, first cycle only:
  - If the output register is empty, or it is being consumed this cycle (out_valid & out_ready), load out_l/out_r and set out_valid.
  - Otherwise drop the new sample and set overrun.
  - In both cases go to IDLE.
- Latency: tick sampled at edge T → out_valid high after edge T+NCH+2.
- out_valid falls on the edge where out_valid & out_ready; out_l/out_r hold their value until the next load.
- sample_tick while busy: ignored; overrun set.
- overrun: set has priority over a simultaneous clr_overrun.
- Inputs change during ACCUM: no effect; only the snapshot is used.
- enable low (any state): next edge forces IDLE, out_valid = 0, out_l = out_r = 0, accumulators 0. overrun is retained. A tick coincident with enable low is ignored.
- Reset mid-operation: immediate return to reset values.

Test Plan:
1. Defaults, SIGNED_MODE=0, all levels 15, pan_l = pan_r = 4'hF, vol 7/7, out_ready=1; tick → out_l = out_r = 16'hF000, out_valid high exactly 6 cycles after tick edge, for one cycle.
2. SIGNED_MODE=1, levels all 15, full pan, vol 7 → 16'h7000; levels all 0 → 16'h8000; levels all 8 → 16'h0000.
3. Panning/volume (unsigned): ch0 = 15, others 0, pan_l = 4'b0001, pan_r = 0, vol_l = 3 → out_l = 15*4 << 7 = 16'h1E00, out_r = 16'h0000.
4. Backpressure: out_ready=0, two ticks 10 cycles apart → first sample held stable, second dropped, overrun = 1; clr_overrun → 0; raise out_ready → one transfer.
5. Tick at cycle 2 of ACCUM → ignored, overrun = 1, first sample still correct; levels changed mid-ACCUM do not alter result.
6. enable dropped during SCALE → next cycle busy=0, out_valid=0, outputs 0; async rst mid-ACCUM → all outputs 0 immediately.
